// File: rtl/avmm_mem_responder.sv
// avmm_mem_responder: Avalon-MM slave memory model with pipelined reads.
// Stores 32-bit words in on-chip RAM and accepts single-word reads/writes
// under s_waitrequest flow control. Read data returns READ_LATENCY cycles
// after acceptance, with at most MAX_PENDING reads outstanding.
// Optional feature: define AVMM_RESP_WAITSTATE_INJECT_EN to add an
// LFSR-driven pseudo-random stall on s_waitrequest.
module avmm_mem_responder #(
    parameter int ADDR_W       = 12,
    parameter int READ_LATENCY = 3,
    parameter int MAX_PENDING  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] s_address,
    input  logic        s_read,
    input  logic        s_write,
    input  logic [31:0] s_writedata,
    output logic        s_waitrequest,
    output logic [31:0] s_readdata,
    output logic        s_readdatavalid,
    output logic        protocol_err
);

    localparam int PEND_W = $clog2(MAX_PENDING + 1);
    localparam int DEPTH  = 1 << ADDR_W;

    logic [ADDR_W-1:0]       word_idx;
    logic                    unused_addr_bits;
    logic [31:0]             mem [DEPTH];
    logic [31:0]             ram_rdata;
    logic [READ_LATENCY-1:0] vld_q;
    logic [31:0]             data_q [READ_LATENCY];
    logic [PEND_W-1:0]       pend_q, pend_d;
    logic                    perr_q, perr_d;
    logic                    cmd_conflict;
    logic                    rd_return;
    logic                    pend_full;
    logic                    stall_inj;
    logic                    rd_accept;
    logic                    wr_accept;

    // Upper address bits alias; byte-lane bits are ignored.
    assign word_idx         = s_address[ADDR_W+1:2];
    assign unused_addr_bits = ^{s_address[31:ADDR_W+2], s_address[1:0]};

`ifdef AVMM_RESP_WAITSTATE_INJECT_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, right-shifting form.
    assign lfsr_d    = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    assign stall_inj = (lfsr_q[1:0] == 2'b00);

    // LFSR advances every cycle, independent of bus activity.
    always_ff @(posedge clk) begin
        if (!rst_n) lfsr_q <= 16'hACE1;
        else        lfsr_q <= lfsr_d;
    end
`else
    assign stall_inj = 1'b0;
`endif

    // Flow control, command acceptance and next-state for counter / error flag.
    always_comb begin
        cmd_conflict  = s_read & s_write;
        rd_return     = vld_q[READ_LATENCY-1];
        // A return in this cycle frees a slot, so a full counter does not stall then.
        pend_full     = (pend_q == PEND_W'(MAX_PENDING)) && !rd_return;
        s_waitrequest = !rst_n || cmd_conflict || (s_read && pend_full) || stall_inj;
        rd_accept     = s_read && !s_write && !s_waitrequest;
        wr_accept     = s_write && !s_read && !s_waitrequest;
        pend_d        = pend_q;
        case ({rd_accept, rd_return})
            2'b10:   pend_d = pend_q + PEND_W'(1);
            2'b01:   pend_d = pend_q - PEND_W'(1);
            default: pend_d = pend_q;
        endcase
        perr_d = perr_q | cmd_conflict;
    end

    // Combinational read port: a write committed last cycle is visible now.
    assign ram_rdata = mem[word_idx];

    // RAM write port.
    // NOTE: the RAM array has no reset so it maps onto block RAM; contents survive rst_n.
    always_ff @(posedge clk) begin
        if (wr_accept) mem[word_idx] <= s_writedata;
    end

    // Read return pipeline; each stage captures data only when a valid tag moves in,
    // so the last stage holds the most recently returned word.
    // NOTE: sequential state uses non-blocking assignments so every stage shifts on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int k = 0; k < READ_LATENCY; k++) data_q[k] <= '0;
        end else begin
            vld_q[0] <= rd_accept;
            if (rd_accept) data_q[0] <= ram_rdata;
            for (int k = 1; k < READ_LATENCY; k++) begin
                vld_q[k] <= vld_q[k-1];
                if (vld_q[k-1]) data_q[k] <= data_q[k-1];
            end
        end
    end

    // Outstanding-read counter and sticky protocol error flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q <= '0;
            perr_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            perr_q <= perr_d;
        end
    end

    assign s_readdatavalid = vld_q[READ_LATENCY-1];
    assign s_readdata      = data_q[READ_LATENCY-1];
    assign protocol_err    = perr_q;

endmodule

// File: tb/tb_avmm_mem_responder.sv
// Testbench for avmm_mem_responder: scoreboard of expected read returns
// (data and return cycle) checked by a monitor, plus per-scenario tasks.
// Two instances: default parameters, and MAX_PENDING=2 for the pending limit.
module tb_avmm_mem_responder;

    localparam int LAT = 3;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] s_address = '0;
    logic        s_read = 1'b0;
    logic        s_write = 1'b0;
    logic [31:0] s_writedata = '0;
    bit          sel = 1'b0;

    logic        a_read, a_write, a_wait, a_rdv, a_perr;
    logic [31:0] a_rdata;
    logic        b_read, b_write, b_wait, b_rdv, b_perr;
    logic [31:0] b_rdata;
    logic        mon_wait, mon_rdv, mon_perr;
    logic [31:0] mon_rdata;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb_q[$];
    exp_t sb_e;

    assign a_read  = s_read  & ~sel;
    assign a_write = s_write & ~sel;
    assign b_read  = s_read  & sel;
    assign b_write = s_write & sel;

    assign mon_wait  = sel ? b_wait  : a_wait;
    assign mon_rdv   = sel ? b_rdv   : a_rdv;
    assign mon_perr  = sel ? b_perr  : a_perr;
    assign mon_rdata = sel ? b_rdata : a_rdata;

    avmm_mem_responder dut_a (
        .clk             (clk),
        .rst_n           (rst_n),
        .s_address       (s_address),
        .s_read          (a_read),
        .s_write         (a_write),
        .s_writedata     (s_writedata),
        .s_waitrequest   (a_wait),
        .s_readdata      (a_rdata),
        .s_readdatavalid (a_rdv),
        .protocol_err    (a_perr)
    );

    avmm_mem_responder #(.ADDR_W(12), .READ_LATENCY(LAT), .MAX_PENDING(2)) dut_b (
        .clk             (clk),
        .rst_n           (rst_n),
        .s_address       (s_address),
        .s_read          (b_read),
        .s_write         (b_write),
        .s_writedata     (s_writedata),
        .s_waitrequest   (b_wait),
        .s_readdata      (b_rdata),
        .s_readdatavalid (b_rdv),
        .protocol_err    (b_perr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every return must match the oldest expectation in data and cycle.
    always @(negedge clk) begin
        if (rst_n && mon_rdv) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL rdv_unexpected cyc=%0d data=%h", cyc, mon_rdata);
            end else begin
                sb_e = sb_q.pop_front();
                if (mon_rdata !== sb_e.data || cyc !== sb_e.cyc) begin
                    errors++;
                    $display("FAIL rdv_return got data=%h cyc=%0d want data=%h cyc=%0d",
                             mon_rdata, cyc, sb_e.data, sb_e.cyc);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Presents a read until accepted; records expected return when push is set.
    task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input bit push,
                            output int acc_cyc, output int stalls);
        s_address = a; s_read = 1'b1; s_write = 1'b0;
        stalls = 0; acc_cyc = -1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!mon_wait) begin
                acc_cyc = cyc;
                if (push) sb_q.push_back('{exp, cyc + LAT});
                @(posedge clk); #1;
                break;
            end
            stalls++;
            @(posedge clk); #1;
        end
        s_read = 1'b0;
        if (acc_cyc < 0) begin
            checks++; errors++;
            $display("FAIL read_timeout addr=%h", a);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bit done;
        s_address = a; s_writedata = d; s_write = 1'b1; s_read = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!mon_wait) done = 1'b1;
            @(posedge clk); #1;
            if (done) break;
        end
        s_write = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL write_timeout addr=%h", a);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 64 && sb_q.size() != 0; i++) @(posedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout left=%0d want 0", sb_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (a_wait !== 1'b1 || a_rdv !== 1'b0 || a_rdata !== 32'h0 || a_perr !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got wait=%b rdv=%b rdata=%h perr=%b want 1 0 0 0",
                     a_wait, a_rdv, a_rdata, a_perr);
        end
        checks++;
        if (dut_a.pend_q !== '0) begin
            errors++;
            $display("FAIL reset_pending got %0d want 0", dut_a.pend_q);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_write_then_read();
        int acc, st;
        bus_write(32'h89C0, 32'h99ABCDEF);
        bus_read(32'h89C0, 32'h99ABCDEF, 1'b1, acc, st);
        drain();
    endtask

    task automatic test_aliasing();
        int acc, st;
        bus_write(32'h89C0, 32'h12345678);
        bus_read(32'h09C2, 32'h12345678, 1'b1, acc, st);
        drain();
    endtask

    task automatic test_back_to_back();
        int acc [3];
        int st;
        logic [31:0] vals [3];
        vals[0] = 32'hA; vals[1] = 32'hB; vals[2] = 32'hC;
        for (int i = 0; i < 3; i++) bus_write(32'(i * 4), vals[i]);
        for (int i = 0; i < 3; i++) begin
            bus_read(32'(i * 4), vals[i], 1'b1, acc[i], st);
            checks++;
            if (st != 0) begin
                errors++;
                $display("FAIL b2b_stall read=%0d got %0d stall cycles want 0", i, st);
            end
        end
        checks++;
        if (acc[2] != acc[0] + 2) begin
            errors++;
            $display("FAIL b2b_accept got span %0d want 2", acc[2] - acc[0]);
        end
        drain();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (a_rdv !== 1'b0 || a_rdata !== 32'hC) begin
            errors++;
            $display("FAIL rdata_hold got rdv=%b rdata=%h want 0 0000000c", a_rdv, a_rdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_pending_limit();
        int acc [4];
        int st [4];
        sel = 1'b1;
        for (int i = 0; i < 4; i++) bus_write(32'((8 + i) * 4), 32'h100 + 32'(i));
        for (int i = 0; i < 4; i++) bus_read(32'((8 + i) * 4), 32'h100 + 32'(i), 1'b1, acc[i], st[i]);
        checks++;
        if (acc[1] != acc[0] + 1) begin
            errors++;
            $display("FAIL pend_second got offset %0d want 1", acc[1] - acc[0]);
        end
        checks++;
        if (acc[2] != acc[0] + LAT || st[2] != 1) begin
            errors++;
            $display("FAIL pend_third got offset %0d stalls %0d want %0d stalls 1",
                     acc[2] - acc[0], st[2], LAT);
        end
        checks++;
        if (acc[3] != acc[1] + LAT) begin
            errors++;
            $display("FAIL pend_fourth got offset %0d want %0d", acc[3] - acc[1], LAT);
        end
        drain();
        sel = 1'b0;
    endtask

    task automatic test_protocol_err();
        int acc, st;
        bus_write(32'h0, 32'h5);
        s_address = 32'h0; s_writedata = 32'hDEADBEEF; s_read = 1'b1; s_write = 1'b1;
        @(negedge clk);
        checks++;
        if (a_wait !== 1'b1) begin
            errors++;
            $display("FAIL perr_wait got %b want 1", a_wait);
        end
        @(posedge clk); #1;
        s_read = 1'b0; s_write = 1'b0;
        checks++;
        if (a_perr !== 1'b1) begin
            errors++;
            $display("FAIL perr_set got %b want 1", a_perr);
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (a_perr !== 1'b1) begin
            errors++;
            $display("FAIL perr_sticky got %b want 1", a_perr);
        end
        bus_read(32'h0, 32'h5, 1'b1, acc, st);
        drain();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++;
        if (a_perr !== 1'b0) begin
            errors++;
            $display("FAIL perr_clear got %b want 0", a_perr);
        end
    endtask

    task automatic test_reset_midflight();
        int acc, st, pulses;
        bus_read(32'h89C0, 32'h0, 1'b0, acc, st);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (a_wait !== 1'b1) begin
            errors++;
            $display("FAIL midrst_wait got %b want 1", a_wait);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        pulses = 0;
        while (cyc <= acc + 10) begin
            @(negedge clk);
            if (a_rdv === 1'b1) pulses++;
            @(posedge clk); #1;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL midrst_pulses got %0d want 0", pulses);
        end
        checks++;
        if (dut_a.pend_q !== '0) begin
            errors++;
            $display("FAIL midrst_pending got %0d want 0", dut_a.pend_q);
        end
        bus_read(32'h89C0, 32'h12345678, 1'b1, acc, st);
        drain();
    endtask

    initial begin
        test_reset();
        test_write_then_read();
        test_aliasing();
        test_back_to_back();
        test_pending_limit();
        test_protocol_err();
        test_reset_midflight();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
